// File: rtl/reglist_seq_encoder.sv
// Register-list sequencer: turns a 16-bit LDM/STM register list into one register index per accepted beat.
// Optional REGLIST_DESCENDING_EN adds a 'descending' input that emits the highest register first.
module reglist_seq_encoder #(
    parameter int N_REGS = 16,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_REGS-1:0] reg_list,
`ifdef REGLIST_DESCENDING_EN
    input  logic              descending,
`endif
    input  logic              reg_ready,
    output logic              busy,
    output logic              reg_valid,
    output logic [IDX_W-1:0]  reg_idx,
    output logic [CNT_W-1:0]  beat_num,
    output logic              first,
    output logic              last,
    output logic [CNT_W-1:0]  total,
    output logic              done,
    output logic              empty_list
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_nxt;
    logic [N_REGS-1:0]  pending;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   total_q;
    logic               empty_q;
    logic               scan_desc;
    logic [IDX_W-1:0]   cur_idx;
    logic               one_left;
    logic               accept;

    function automatic logic [IDX_W-1:0] sel_index(input logic [N_REGS-1:0] m,
                                                   input logic hi_first);
        sel_index = '0;
        if (hi_first) begin
            for (int i = 0; i < N_REGS; i++)
                if (m[i]) sel_index = IDX_W'(i);
        end else begin
            for (int i = N_REGS - 1; i >= 0; i--)
                if (m[i]) sel_index = IDX_W'(i);
        end
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [N_REGS-1:0] m);
        popcount = '0;
        for (int i = 0; i < N_REGS; i++)
            popcount = popcount + CNT_W'(m[i]);
    endfunction

    // Index comes from the registered pending mask only, so it is stable for the whole cycle.
    assign cur_idx  = sel_index(pending, scan_desc);
    assign one_left = (pending != '0) && ((pending & (pending - N_REGS'(1))) == '0);
    assign accept   = (state == SCAN) && reg_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (reg_list != '0) ? SCAN : DONE;
            SCAN: if (accept && one_left) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= '0;
            beat_cnt <= '0;
            total_q  <= '0;
            empty_q  <= 1'b0;
        end else if (state == IDLE && start) begin
            pending  <= reg_list;
            beat_cnt <= '0;
            total_q  <= popcount(reg_list);
            empty_q  <= (reg_list == '0);
        end else if (accept) begin
            pending  <= pending & ~(N_REGS'(1) << cur_idx);
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

`ifdef REGLIST_DESCENDING_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                     scan_desc <= 1'b0;
        else if (state == IDLE && start) scan_desc <= descending;
    end
`else
    assign scan_desc = 1'b0;
`endif

    assign busy       = (state != IDLE);
    assign reg_valid  = (state == SCAN);
    assign reg_idx    = reg_valid ? cur_idx : '0;
    assign beat_num   = beat_cnt;
    assign first      = reg_valid && (beat_cnt == '0);
    assign last       = reg_valid && one_left;
    assign total      = total_q;
    assign done       = (state == DONE);
    assign empty_list = done && empty_q;

endmodule

// File: tb/tb_reglist_seq_encoder.sv
// Scoreboard bench for reglist_seq_encoder: a list-level model queues expected beats/completions,
// a negedge monitor compares whatever the DUT presents.
module tb_reglist_seq_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] reg_list;
    logic        descending;
    logic        reg_ready;
    logic        busy, reg_valid, first, last, done, empty_list;
    logic [3:0]  reg_idx;
    logic [4:0]  beat_num, total;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        bit         is_done;
        logic [3:0] idx;
        logic [4:0] bn;
        bit         first;
        bit         last;
        logic [4:0] total;
        bit         empty;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    reglist_seq_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .reg_list   (reg_list),
`ifdef REGLIST_DESCENDING_EN
        .descending (descending),
`endif
        .reg_ready  (reg_ready),
        .busy       (busy),
        .reg_valid  (reg_valid),
        .reg_idx    (reg_idx),
        .beat_num   (beat_num),
        .first      (first),
        .last       (last),
        .total      (total),
        .done       (done),
        .empty_list (empty_list)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: walk the list in transfer order, one expected beat per set bit, then the completion.
    task automatic push_txn(input logic [15:0] l, input bit d);
        exp_t e;
        int n;
        int b;
        n = $countones(l);
        b = 0;
        for (int k = 0; k < 16; k++) begin
            int i;
            i = d ? 15 - k : k;
            if (l[i]) begin
                e.is_done = 0;
                e.idx     = 4'(i);
                e.bn      = 5'(b);
                e.first   = (b == 0);
                e.last    = (b == n - 1);
                e.total   = 5'(n);
                e.empty   = 0;
                q.push_back(e);
                b++;
            end
        end
        e.is_done = 1;
        e.idx     = '0;
        e.bn      = 5'(n);
        e.first   = 0;
        e.last    = 0;
        e.total   = 5'(n);
        e.empty   = (n == 0);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reg_valid || done) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {30'd0, reg_valid, done}, 32'd0);
            end else if (reg_valid) begin
                chk("beat_expected", 32'(q[0].is_done), 32'd0);
                chk("reg_idx",  32'(reg_idx),  32'(q[0].idx));
                chk("beat_num", 32'(beat_num), 32'(q[0].bn));
                chk("first",    32'(first),    32'(q[0].first));
                chk("last",     32'(last),     32'(q[0].last));
                chk("total",    32'(total),    32'(q[0].total));
                chk("busy_scan", 32'(busy), 32'd1);
                chk("done_in_scan", 32'(done), 32'd0);
                if (reg_ready) void'(q.pop_front());
            end else begin
                chk("done_expected", 32'(q[0].is_done), 32'd1);
                chk("empty_list",    32'(empty_list),   32'(q[0].empty));
                chk("done_total",    32'(total),        32'(q[0].total));
                chk("done_beat_num", 32'(beat_num),     32'(q[0].bn));
                chk("busy_done",     32'(busy),         32'd1);
                void'(q.pop_front());
            end
        end
    end

    // mode: 0 ready high, 1 toggle 1/0, 2 random. glitch: 0 none, 1 random starts, 2 start with FFFF.
    task automatic run_txn(input logic [15:0] l, input bit d, input int mode, input int glitch);
        bit seen;
        bit tog;
        int cyc;
        start      = 1'b1;
        reg_list   = l;
        descending = d;
        reg_ready  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        tog        = 1'b0;
        push_txn(l, d);
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                seen  = 1;
                start = 1'b0;
            end else begin
                case (glitch)
                    1: begin start = 1'($urandom_range(0, 1)); reg_list = 16'($urandom); end
                    2: begin start = 1'b1; reg_list = 16'hFFFF; end
                    default: begin start = 1'b0; reg_list = 16'($urandom); end
                endcase
                descending = 1'($urandom_range(0, 1));
                case (mode)
                    0: reg_ready = 1'b1;
                    1: begin reg_ready = tog; tog = ~tog; end
                    default: reg_ready = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        reg_list   = '0;
        descending = 1'b0;
        reg_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_valid", 32'(reg_valid), 32'd0);
        chk("rst_total", 32'(total), 32'd0);
        chk("rst_beat",  32'(beat_num), 32'd0);
        chk("rst_done",  32'(done | empty_list | first | last), 32'd0);
        chk("rst_idx",   32'(reg_idx), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(16'h8001, 1'b0, 0, 0);
        run_txn(16'h0000, 1'b0, 0, 0);
        run_txn(16'hFFFF, 1'b0, 1, 0);
        run_txn(16'h0130, 1'b0, 0, 2);
`ifdef REGLIST_DESCENDING_EN
        run_txn(16'h00F0, 1'b1, 0, 0);
        run_txn(16'hFFFF, 1'b1, 2, 1);
`endif

        // Reset after the third accepted beat of 16'h00FF.
        start     = 1'b1;
        reg_list  = 16'h00FF;
        descending = 1'b0;
        reg_ready = 1'b1;
        push_txn(16'h00FF, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        reg_ready = 1'b0;
        @(posedge clk); #1;
        q.delete();
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_valid", 32'(reg_valid), 32'd0);
        chk("abort_total", 32'(total), 32'd0);
        chk("abort_beat",  32'(beat_num), 32'd0);
        chk("abort_done",  32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done), 32'd0);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] l;
            int sel;
            sel = $urandom_range(0, 7);
            if (sel == 0)      l = 16'h0000;
            else if (sel == 1) l = 16'hFFFF;
            else if (sel < 4)  l = 16'($urandom) & 16'($urandom);
            else               l = 16'($urandom);
`ifdef REGLIST_DESCENDING_EN
            run_txn(l, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 1));
`else
            run_txn(l, 1'b0, $urandom_range(0, 2), $urandom_range(0, 1));
`endif
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/reglist_seq_encoder.md
Name: reglist_seq_encoder

Overview:
- Encoder-side counterpart to the register-file 4-to-16 write-select decode: converts a 16-bit register list (LDM/STM style) into a stream of 4-bit register indices, one per accepted beat.
- Sits between the instruction decode/control unit and the register-file port during block data transfers.
- Order is lowest register first by default.
- Provides a valid/ready handshake, beat numbering and first/last flags so the load/store unit can generate addresses.

Parameters:
- N_REGS, 16, width of the register list; fixed at 16 for this core.
- IDX_W, 4, width of the emitted index; must equal log2(N_REGS).
- CNT_W, 5, width of the beat count and popcount outputs; must hold N_REGS.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  launch request; sampled only in IDLE.
- reg_list  input  16  register list; bit i set means register i is transferred; sampled with start.
- reg_ready  input  1  consumer accepts the current beat.
- busy  output  1  high in SCAN and DONE.
- reg_valid  output  1  current beat is valid.
- reg_idx  output  4  register number of the current beat.
- beat_num  output  5  zero-based index of the current beat.
- first  output  1  current beat is beat 0.
- last  output  1  current beat is the final one.
- total  output  5  popcount of the latched list; held until the next start.
- done  output  1  one-cycle completion pulse.
- empty_list  output  1  one-cycle pulse, coincident with done, when the latched list was zero.

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - The pending mask, beat_num and total clear to 0.
  - All outputs read 0 on the following cycle.
  - Reset overrides any in-flight transfer; no done is produced for the aborted transfer.
- States: IDLE, SCAN, DONE.
- IDLE:
  - busy=0 and reg_valid=0.
  - When start=1: latch reg_list into the pending mask, load total=popcount(reg_list) and set beat_num=0.
  - If reg_list is nonzero, go to SCAN; otherwise go to DONE with the empty flag set.
- SCAN:
  - reg_valid=1 throughout.
  - reg_idx is the index of the lowest set bit of the pending mask. It is a priority encode of a registered value, so reg_idx is glitch-free relative to clk.
  - first = (beat_num==0).
  - last = (pending has exactly one bit set).
  - On a cycle with reg_valid & reg_ready:
    - Clear that bit in pending and increment beat_num.
    - If last, go to DONE.
  - While reg_ready=0: reg_idx, beat_num, first and last hold stable.
- DONE:
  - done=1 for exactly one cycle.
  - empty_list=1 in the same cycle if the list was zero.
  - reg_valid=0.
  - Next state is IDLE.
- Latency:
  - start at edge T gives the first reg_valid in the cycle after T.
  - The final acceptance at edge E gives done in the cycle after E.
  - The block returns to IDLE one cycle later, so a new start is accepted at the edge ending the DONE cycle + 1.
- Throughput: one beat per cycle when reg_ready is held high. A 16-register list takes 16 cycles in SCAN.
- start while busy is ignored. The latched list, total and order are unaffected.
- reg_list changes after the start edge have no effect.
- total=16 needs all 5 bits. beat_num never exceeds total-1 while reg_valid=1.
- After done, total holds its value until the next start or reset. beat_num holds its final value (equal to total).

Optional Feature:
- Macro: REGLIST_DESCENDING_EN.
- When defined:
  - Adds input port descending (1 bit), sampled with start.
  - descending=1 makes SCAN emit the highest set bit first (STMDB/LDMDA ordering).
  - last, first and beat_num semantics are unchanged.
- When undefined:
  - The port is absent.
  - Order is always ascending, identical to descending=0.

Test Plan:
- reg_list=16'h8001 with start, reg_ready=1 -> total=2. Beats: idx 0 (first=1, beat_num=0), then idx 15 (last=1, beat_num=1). done pulses one cycle later, empty_list=0.
- reg_list=16'h0000 with start -> the next cycle has done=1, empty_list=1, total=0, and reg_valid never asserts.
- reg_list=16'hFFFF, reg_ready toggling 1,0,1,0 -> 16 beats, idx 0..15 in order. reg_idx and beat_num are held on stall cycles. last is set only on idx 15. total=16.
- reg_list=16'h0130, with start pulsed again carrying 16'hFFFF during SCAN -> only idx 4, 5, 8 are emitted and total stays 3.
- reg_list=16'h00FF, rst_n=0 after the third accepted beat -> the next cycle has busy=0, reg_valid=0, total=0, and no done pulse.
- With REGLIST_DESCENDING_EN: descending=1, reg_list=16'h00F0 -> idx 7, 6, 5, 4; first on 7, last on 4.
